// File: rtl/hawk_lamp_driver.sv
// hawk_lamp_driver: turns the hawk_controller phase code into HAWK beacon and
// pedestrian-head lamp drives. It owns all flash and wig-wag timing and
// restarts the flash phase whenever the phase code changes. An invalid code
// that persists for FAULT_CYCLES cycles latches a flashing-red fail-safe,
// which only reset can clear.
module hawk_lamp_driver #(
  parameter int FLASH_HALF   = 25,  // cycles per flash half-period, >= 2
  parameter int FAULT_CYCLES = 4    // consecutive invalid cycles to latch fault, >= 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] lights,
  output logic       lamp_y,
  output logic       lamp_rl,
  output logic       lamp_rr,
  output logic       ped_walk,
  output logic       ped_dw,
  output logic       fault
);

  typedef enum logic [3:0] {
    PH_DARK     = 4'h0,
    PH_FLASH_Y  = 4'h1,
    PH_SOLID_Y  = 4'h2,
    PH_SOLID_R  = 4'h3,
    PH_WIGWAG_R = 4'h4
  } phase_e;

  localparam int CNT_W = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
  localparam int INV_W = $clog2(FAULT_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLASH_HALF - 1);
  localparam logic [INV_W-1:0] INV_MAX  = INV_W'(FAULT_CYCLES);
  localparam logic [INV_W-1:0] INV_PRE  = INV_W'(FAULT_CYCLES - 1);

  phase_e           phase_q;
  logic [CNT_W-1:0] cnt;
  logic             flash_on;
  logic [INV_W-1:0] inv_cnt;
  logic             fault_q;

  logic             lights_valid;
  logic             phase_change;

  // Codes above WIGWAG_R are undefined and treated as a controller fault.
  assign lights_valid = (lights <= 4'h4);
  assign phase_change = lights_valid && (lights != 4'(phase_q));

  // Phase register, free-running flash timer, invalid-code counter and fault latch.
  // NOTE: every register here uses <= so all of them see pre-edge values;
  // a blocking = would let later statements read already-updated state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q  <= PH_DARK;
      cnt      <= '0;
      flash_on <= 1'b1;
      inv_cnt  <= '0;
      fault_q  <= 1'b0;
    end else begin
      // A new valid phase always starts on a fresh, lit half-period.
      if (phase_change) begin
        phase_q  <= phase_e'(lights);
        cnt      <= '0;
        flash_on <= 1'b1;
      end else if (cnt == CNT_LAST) begin
        cnt      <= '0;
        flash_on <= ~flash_on;
      end else begin
        cnt      <= cnt + CNT_W'(1);
      end

      // Invalid codes hold the phase; only a long enough run of them trips the latch.
      if (!lights_valid) begin
        if (inv_cnt != INV_MAX) begin
          inv_cnt <= inv_cnt + INV_W'(1);
        end
        if (inv_cnt >= INV_PRE) begin
          fault_q <= 1'b1;
        end
      end else begin
        inv_cnt <= '0;
      end
    end
  end

  // Moore decode of the registered phase, flash state and fault latch to lamp drives.
  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    lamp_y   = 1'b0;
    lamp_rl  = 1'b0;
    lamp_rr  = 1'b0;
    ped_walk = 1'b0;
    ped_dw   = 1'b1;
    fault    = fault_q;
    if (fault_q) begin
      // Fail-safe: both reds flash in unison regardless of the phase.
      lamp_rl = flash_on;
      lamp_rr = flash_on;
    end else begin
      case (phase_q)
        PH_DARK: begin
        end
        PH_FLASH_Y: begin
          lamp_y = flash_on;
        end
        PH_SOLID_Y: begin
          lamp_y = 1'b1;
        end
        PH_SOLID_R: begin
          lamp_rl  = 1'b1;
          lamp_rr  = 1'b1;
          ped_walk = 1'b1;
          ped_dw   = 1'b0;
        end
        PH_WIGWAG_R: begin
          lamp_rl = flash_on;
          lamp_rr = ~flash_on;
          ped_dw  = flash_on;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hawk_lamp_driver.sv
// Directed self-checking bench for hawk_lamp_driver with FLASH_HALF=25 and
// FAULT_CYCLES=4. Inputs change and outputs are sampled 1 ns after each
// rising edge. The observed vector is {lamp_y, lamp_rl, lamp_rr, ped_walk, ped_dw, fault}.
module tb_hawk_lamp_driver;

  localparam int FLASH_HALF   = 25;
  localparam int FAULT_CYCLES = 4;

  // Expected output vectors {y, rl, rr, walk, dw, fault}
  localparam logic [5:0] O_DARK   = 6'b000010;
  localparam logic [5:0] O_Y_ON   = 6'b100010;
  localparam logic [5:0] O_Y_OFF  = 6'b000010;
  localparam logic [5:0] O_SOLIDR = 6'b011100;
  localparam logic [5:0] O_WW_ON  = 6'b010010;
  localparam logic [5:0] O_WW_OFF = 6'b001000;
  localparam logic [5:0] O_FLT_ON = 6'b011011;
  localparam logic [5:0] O_FLT_OFF= 6'b000011;

  logic       clk;
  logic       rst_n;
  logic [3:0] lights;
  logic       lamp_y, lamp_rl, lamp_rr, ped_walk, ped_dw, fault;
  logic [5:0] obs;

  int checks = 0;
  int errors = 0;

  hawk_lamp_driver #(
    .FLASH_HALF  (FLASH_HALF),
    .FAULT_CYCLES(FAULT_CYCLES)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .lights  (lights),
    .lamp_y  (lamp_y),
    .lamp_rl (lamp_rl),
    .lamp_rr (lamp_rr),
    .ped_walk(ped_walk),
    .ped_dw  (ped_dw),
    .fault   (fault)
  );

  assign obs = {lamp_y, lamp_rl, lamp_rr, ped_walk, ped_dw, fault};

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (y rl rr walk dw fault)", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 ns past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n  = 1'b0;
    lights = 4'h0;
    step(2);
    check("reset_state", obs, O_DARK);

    // DARK after reset
    rst_n = 1'b1;
    step(1);
    check("dark_after_reset", obs, O_DARK);

    // FLASH_Y: lit one edge after the change, then 25-cycle half-periods
    lights = 4'h1;
    step(1);
    check("flash_y_first_on", obs, O_Y_ON);
    for (int t = 0; t < 4; t++) begin
      step(FLASH_HALF - 1);
      check($sformatf("flash_y_hold_%0d", t), obs, (t % 2 == 0) ? O_Y_ON : O_Y_OFF);
      step(1);
      check($sformatf("flash_y_toggle_%0d", t), obs, (t % 2 == 0) ? O_Y_OFF : O_Y_ON);
    end

    // SOLID_Y, SOLID_R, WIGWAG_R with 20-cycle dwells
    lights = 4'h2;
    step(1);
    check("solid_y_enter", obs, O_Y_ON);
    step(19);
    check("solid_y_steady", obs, O_Y_ON);
    lights = 4'h3;
    step(1);
    check("solid_r_enter", obs, O_SOLIDR);
    step(19);
    check("solid_r_steady", obs, O_SOLIDR);
    lights = 4'h4;
    step(1);
    check("wigwag_enter", obs, O_WW_ON);
    step(FLASH_HALF - 1);
    check("wigwag_hold", obs, O_WW_ON);
    step(1);
    check("wigwag_swap", obs, O_WW_OFF);

    // Phase change 1->4 sampled while cnt == 17
    lights = 4'h1;
    step(1);
    step(17);
    check("mid_half_before", obs, O_Y_ON);
    lights = 4'h4;
    step(1);
    check("mid_half_restart", obs, O_WW_ON);
    step(FLASH_HALF - 1);
    check("mid_half_hold", obs, O_WW_ON);
    step(1);
    check("mid_half_toggle", obs, O_WW_OFF);

    // Short invalid burst inside WIGWAG_R must not restart the flash timer
    lights = 4'h3;
    step(1);
    lights = 4'h4;
    step(1);                  // restart: cnt=0, lit
    step(10);                 // cnt=10
    lights = 4'hA;
    step(3);                  // cnt=13
    check("ww_burst_outputs", obs, O_WW_ON);
    lights = 4'h4;
    step(1);                  // cnt=14, no restart
    step(10);                 // cnt=24
    check("ww_burst_hold", obs, O_WW_ON);
    step(1);
    check("ww_burst_no_restart", obs, O_WW_OFF);

    // 3-cycle invalid burst inside SOLID_R: no disturbance, no fault
    lights = 4'h3;
    step(1);
    for (int i = 0; i < FAULT_CYCLES - 1; i++) begin
      lights = 4'hA;
      step(1);
      check($sformatf("short_burst_%0d", i), obs, O_SOLIDR);
    end
    lights = 4'h3;
    step(1);
    check("short_burst_return", obs, O_SOLIDR);

    // 4-cycle invalid burst latches the fault
    lights = 4'h4;
    step(1);
    lights = 4'h3;
    step(1);                  // restart: cnt=0, lit
    lights = 4'hA;
    step(FAULT_CYCLES - 1);
    check("fault_not_yet", obs, O_SOLIDR);
    step(1);                  // cnt=4
    check("fault_latched", obs, O_FLT_ON);
    lights = 4'h3;
    step(1);                  // cnt=5
    check("fault_sticky", obs, O_FLT_ON);
    step(19);                 // cnt=24
    check("fault_flash_hold", obs, O_FLT_ON);
    step(1);
    check("fault_flash_off", obs, O_FLT_OFF);

    // One-cycle reset pulse mid-flash while faulted
    step(10);
    rst_n = 1'b0;
    step(1);
    check("reset_from_fault", obs, O_DARK);
    rst_n  = 1'b1;
    lights = 4'h3;
    step(1);
    check("resume_after_reset", obs, O_SOLIDR);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
